pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush/forward controller for the 5-stage core (IF/ID/EX/MEM/WB). Tracks rd of in-flight

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_ctrl_hazard_cmp.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry, forward selects, FSM states.
package pipe_ctrl_pkg;

  localparam int unsigned RF_AW      = 5;
  localparam int unsigned NUM_STAGES = 3;

  localparam logic [RF_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    FREEZE = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic             valid;
    logic [RF_AW-1:0] rd;
    logic             wr_en;
    logic             is_load;
  } sb_entry_t;

endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// Compares one in-flight scoreboard entry against one ID source operand.
module pipe_ctrl_hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  sb_entry_t        entry,
  input  logic [RF_AW-1:0] rs,
  input  logic             rs_used,
  output logic             hit_c
);

  // Load flag is consumed by the top, not by the match itself.
  logic unused_load;
  assign unused_load = entry.is_load;

  // x0 is hard-wired, so it never creates a dependency.
  assign hit_c = entry.valid & entry.wr_en & rs_used &
                 (entry.rd == rs) & (rs != REG_ZERO);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage core; tracks rd of EX/MEM/WB instructions.
// PIPELINE_HAZARD_FWD_EN: enables EX operand forwarding; otherwise every RAW dependency stalls.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_rs1_used,
  input  logic              i_id_rs2_used,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_reg_wr_en,
  input  logic              i_id_is_load,
  input  logic              i_ex_pc_sel,
  input  logic              i_mem_busy,
  output logic              o_if_stall,
  output logic              o_id_stall,
  output logic              o_flush_if_id,
  output logic              o_flush_id_ex,
  output logic              o_freeze,
  output logic [1:0]        o_fwd_a_sel,
  output logic [1:0]        o_fwd_b_sel,
  output logic              o_ex_valid,
  output logic              o_mem_valid,
  output logic              o_wb_valid
);

  localparam int unsigned CNT_W = 3;
`ifdef PIPELINE_HAZARD_FWD_EN
  localparam int unsigned NUM_CMP = 2;
`else
  localparam int unsigned NUM_CMP = 3;
`endif

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sb_entry_t        sb_q [NUM_STAGES];
  sb_entry_t        id_entry;
  logic [RF_AW-1:0] rs1, rs2;
  logic [NUM_CMP-1:0] hit_a, hit_b;
  logic             redirect;
  logic             hazard_stall;
  logic             ex_bubble;

  assign rs1      = RF_AW'(i_id_rs1);
  assign rs2      = RF_AW'(i_id_rs2);
  assign id_entry = '{valid: i_id_valid, rd: RF_AW'(i_id_rd),
                      wr_en: i_id_reg_wr_en, is_load: i_id_is_load};

  // Index 0 = EX, 1 = MEM, 2 = WB.
  for (genvar s = 0; s < NUM_CMP; s++) begin : g_cmp
    pipe_ctrl_hazard_cmp u_cmp_a (
      .entry   (sb_q[s]),
      .rs      (rs1),
      .rs_used (i_id_rs1_used),
      .hit_c   (hit_a[s])
    );
    pipe_ctrl_hazard_cmp u_cmp_b (
      .entry   (sb_q[s]),
      .rs      (rs2),
      .rs_used (i_id_rs2_used),
      .hit_c   (hit_b[s])
    );
  end

  assign redirect = i_ex_pc_sel & sb_q[0].valid;

`ifdef PIPELINE_HAZARD_FWD_EN
  // Only a load still in EX cannot be forwarded in time.
  assign hazard_stall = i_id_valid & sb_q[0].is_load & (hit_a[0] | hit_b[0]);
`else
  assign hazard_stall = i_id_valid & ((|hit_a) | (|hit_b));
`endif

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and control outputs; FREEZE resolves like RUN once memory is ready.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    o_if_stall    = 1'b0;
    o_id_stall    = 1'b0;
    o_flush_if_id = 1'b0;
    o_flush_id_ex = 1'b0;
    o_freeze      = 1'b0;
    if (i_rst) begin
      o_flush_if_id = 1'b1;
      o_flush_id_ex = 1'b1;
      state_d       = RUN;
      cnt_d         = '0;
    end else begin
      case (state_q)
        RUN, FREEZE: begin
          if (i_mem_busy) begin
            o_freeze   = 1'b1;
            o_if_stall = 1'b1;
            o_id_stall = 1'b1;
            state_d    = FREEZE;
          end else if (redirect) begin
            o_flush_if_id = 1'b1;
            o_flush_id_ex = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = RUN;
            if (hazard_stall) begin
              o_if_stall    = 1'b1;
              o_id_stall    = 1'b1;
              o_flush_id_ex = 1'b1;
            end
          end
        end
        FLUSH: begin
          o_flush_if_id = 1'b1;
          if (i_mem_busy) begin
            o_freeze   = 1'b1;
            o_if_stall = 1'b1;
            o_id_stall = 1'b1;
          end else if (cnt_q <= CNT_W'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign ex_bubble = o_flush_id_ex | o_id_stall | ~i_id_valid;

  // Scoreboard shifts with the pipe; held while memory is busy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(NUM_STAGES); i++) sb_q[i] <= '0;
    end else if (!o_freeze) begin
      sb_q[2] <= sb_q[1];
      sb_q[1] <= sb_q[0];
      if (ex_bubble) sb_q[0] <= '0;
      else           sb_q[0] <= id_entry;
    end
  end

  assign o_ex_valid  = sb_q[0].valid;
  assign o_mem_valid = sb_q[1].valid;
  assign o_wb_valid  = sb_q[2].valid;

`ifdef PIPELINE_HAZARD_FWD_EN
  fwd_sel_e fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;

  // Newest producer wins: current EX (moving to MEM) beats current MEM (moving to WB).
  always_comb begin
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (hit_a[0])      fwd_a_d = FWD_MEM;
    else if (hit_a[1]) fwd_a_d = FWD_WB;
    if (hit_b[0])      fwd_b_d = FWD_MEM;
    else if (hit_b[1]) fwd_b_d = FWD_WB;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (!o_freeze) begin
      if (ex_bubble) begin
        fwd_a_q <= FWD_RF;
        fwd_b_q <= FWD_RF;
      end else begin
        fwd_a_q <= fwd_a_d;
        fwd_b_q <= fwd_b_d;
      end
    end
  end

  assign o_fwd_a_sel = fwd_a_q;
  assign o_fwd_b_sel = fwd_b_q;

  // WB entry only reports its valid bit when forwarding covers the hazard.
  logic unused_wb;
  assign unused_wb = ^{sb_q[2].rd, sb_q[2].wr_en, sb_q[2].is_load};
`else
  assign o_fwd_a_sel = 2'(FWD_RF);
  assign o_fwd_b_sel = 2'(FWD_RF);
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3); expectations follow PIPELINE_HAZARD_FWD_EN.
module tb_pipeline_hazard_ctrl;

  logic       i_clk;
  logic       i_rst;
  logic       i_id_valid;
  logic [4:0] i_id_rs1, i_id_rs2, i_id_rd;
  logic       i_id_rs1_used, i_id_rs2_used;
  logic       i_id_reg_wr_en, i_id_is_load;
  logic       i_ex_pc_sel, i_mem_busy;
  logic       o_if_stall, o_id_stall, o_flush_if_id, o_flush_id_ex, o_freeze;
  logic [1:0] o_fwd_a_sel, o_fwd_b_sel;
  logic       o_ex_valid, o_mem_valid, o_wb_valid;

  int total = 0;
  int bad   = 0;

  pipeline_hazard_ctrl #(.REG_AW(5), .FLUSH_CYCLES(3)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_id_valid     (i_id_valid),
    .i_id_rs1       (i_id_rs1),
    .i_id_rs2       (i_id_rs2),
    .i_id_rs1_used  (i_id_rs1_used),
    .i_id_rs2_used  (i_id_rs2_used),
    .i_id_rd        (i_id_rd),
    .i_id_reg_wr_en (i_id_reg_wr_en),
    .i_id_is_load   (i_id_is_load),
    .i_ex_pc_sel    (i_ex_pc_sel),
    .i_mem_busy     (i_mem_busy),
    .o_if_stall     (o_if_stall),
    .o_id_stall     (o_id_stall),
    .o_flush_if_id  (o_flush_if_id),
    .o_flush_id_ex  (o_flush_id_ex),
    .o_freeze       (o_freeze),
    .o_fwd_a_sel    (o_fwd_a_sel),
    .o_fwd_b_sel    (o_fwd_b_sel),
    .o_ex_valid     (o_ex_valid),
    .o_mem_valid    (o_mem_valid),
    .o_wb_valid     (o_wb_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", tag, got, exp);
    end
  endtask

  // {if_stall, id_stall, flush_if_id, flush_id_ex, freeze}
  function automatic logic [7:0] ctl();
    return {3'b000, o_if_stall, o_id_stall, o_flush_if_id, o_flush_id_ex, o_freeze};
  endfunction

  function automatic logic [7:0] vld();
    return {5'b00000, o_ex_valid, o_mem_valid, o_wb_valid};
  endfunction

  function automatic logic [7:0] fwd();
    return {4'b0000, o_fwd_a_sel, o_fwd_b_sel};
  endfunction

  task automatic set_id(input logic v, input logic [4:0] s1, input logic u1,
                        input logic [4:0] s2, input logic u2,
                        input logic [4:0] rd, input logic wr, input logic ld);
    i_id_valid     = v;
    i_id_rs1       = s1;
    i_id_rs1_used  = u1;
    i_id_rs2       = s2;
    i_id_rs2_used  = u2;
    i_id_rd        = rd;
    i_id_reg_wr_en = wr;
    i_id_is_load   = ld;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drain();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    i_rst       = 1'b1;
    i_ex_pc_sel = 1'b0;
    i_mem_busy  = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_ctl", ctl(), 8'h06);
    check("rst_vld", vld(), 8'h00);
    check("rst_fwd", fwd(), 8'h00);
    i_rst = 1'b0;

    // x0 never hazards or forwards
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    settle();
    check("x0_prod_ctl", ctl(), 8'h00);
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
    settle();
    check("x0_ctl", ctl(), 8'h00);
    tick();
    check("x0_fwd", fwd(), 8'h00);
    check("x0_vld", vld(), 8'h06);
    drain();
    check("drain_vld", vld(), 8'h00);

`ifdef PIPELINE_HAZARD_FWD_EN
    // addi x5 in EX, add x6,x5,x1 in ID
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    settle();
    check("raw_ctl", ctl(), 8'h00);
    tick();
    check("raw_fwd", fwd(), 8'h04);
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    check("bubble_fwd", fwd(), 8'h00);
    drain();

    // lw x5 in EX, add x6,x1,x5 in ID
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    settle();
    check("lu_ctl", ctl(), 8'h1A);
    tick();
    check("lu_bubble_vld", vld(), 8'h02);
    check("lu_release", ctl(), 8'h00);
    tick();
    check("lu_fwd", fwd(), 8'h02);
    check("lu_vld", vld(), 8'h05);
    drain();
`else
    // addi x5 then add x6,x5,x5 stalls until x5 leaves WB
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    settle();
    check("dep_ctl_ex", ctl(), 8'h1A);
    tick();
    check("dep_ctl_mem", ctl(), 8'h1A);
    tick();
    check("dep_ctl_wb", ctl(), 8'h1A);
    tick();
    check("dep_release", ctl(), 8'h00);
    check("dep_fwd", fwd(), 8'h00);
    tick();
    check("dep_vld", vld(), 8'h04);
    drain();

    // reset in the middle of a stall
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    settle();
    check("stall_pre_rst", ctl(), 8'h1A);
    tick();
    i_rst = 1'b1;
    settle();
    check("rst_mid_ctl", ctl(), 8'h06);
    tick();
    check("rst_mid_vld", vld(), 8'h00);
    i_rst = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    check("rst_mid_after", ctl(), 8'h00);
`endif

    // jal x5 redirects while ID reads x5: redirect wins, flush IF/ID for 3 cycles
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    i_ex_pc_sel = 1'b1;
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0);
    settle();
    check("rd_ctl0", ctl(), 8'h06);
    tick();
    i_ex_pc_sel = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    check("rd_ctl1", ctl(), 8'h04);
    check("rd_ex_bubble", vld(), 8'h02);
    tick();
    check("rd_ctl2", ctl(), 8'h04);
    tick();
    check("rd_ctl3", ctl(), 8'h00);
    drain();

    // memory busy 4 cycles with a pending redirect in EX
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    i_ex_pc_sel = 1'b1;
    i_mem_busy  = 1'b1;
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("busy_ctl%0d", i), ctl(), 8'h19);
      check($sformatf("busy_vld%0d", i), vld(), 8'h04);
      tick();
    end
    i_mem_busy = 1'b0;
    settle();
    check("busy_redirect", ctl(), 8'h06);
    tick();
    i_ex_pc_sel = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    check("busy_flush1", ctl(), 8'h04);
    tick();
    check("busy_flush2", ctl(), 8'h04);
    tick();
    check("busy_flush_end", ctl(), 8'h00);

    // reset while frozen
    i_mem_busy = 1'b1;
    tick();
    i_rst = 1'b1;
    settle();
    check("rst_freeze_ctl", ctl(), 8'h06);
    tick();
    i_rst      = 1'b0;
    i_mem_busy = 1'b0;
    settle();
    check("rst_freeze_after", ctl(), 8'h00);
    check("rst_freeze_vld", vld(), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
